ysyx_22040759_gpr_sb: RTL

//  Multi-port general-purpose register file with an integrated write-ownership scoreboard.

---
 rtl/ysyx_22040759_gpr_pkg.sv | 37 +++
 rtl/ysyx_22040759_gpr_rdport.sv | 46 ++++
 rtl/ysyx_22040759_gpr.sv | 104 ++++++++++
 3 files changed

// File: rtl/ysyx_22040759_gpr_pkg.sv
// Shared constants, types and the write-lane arbitration helper for the GPR/scoreboard slice.
// Lane vectors are passed to find_lane zero-extended to MAX_NWR lanes of MAX_AW bits.
package ysyx_22040759_gpr_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;
    localparam int ZERO_REG = 0;

    localparam int MAX_NWR = 8;
    localparam int MAX_AW  = 8;
    localparam int LANE_W  = $clog2(MAX_NWR);

    typedef struct packed {
        logic              hit;
        logic [LANE_W-1:0] lane;
    } lane_match_t;

    // Later lanes overwrite earlier matches, so the highest-index lane wins.
    function automatic lane_match_t find_lane(
        input logic [MAX_NWR-1:0]        en,
        input logic [MAX_NWR*MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0]         target
    );
        lane_match_t m;
        m = '0;
        for (int i = 0; i < MAX_NWR; i++) begin
            if (en[i] && (addr[i*MAX_AW +: MAX_AW] == target)) begin
                m.hit  = 1'b1;
                m.lane = i[LANE_W-1:0];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22040759_gpr_rdport.sv
// One combinational read port: storage mux, x0 masking and, with GPR_BYPASS_EN defined,
// a same-cycle bypass from the active write lanes.
module ysyx_22040759_gpr_rdport
    import ysyx_22040759_gpr_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NWR  = NWR_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]             addr,
    input  logic [XLEN-1:0]           regs [NREG],
    input  logic [NREG-1:0]           busy,
`ifdef GPR_BYPASS_EN
    input  logic [MAX_NWR-1:0]        wen,
    input  logic [MAX_NWR*MAX_AW-1:0] waddr,
    input  logic [NWR*XLEN-1:0]       wdata,
    input  logic                      claim_ready,
    input  logic [AW-1:0]             claim_addr,
`endif
    output logic [XLEN-1:0]           data,
    output logic                      rbusy
);

`ifdef GPR_BYPASS_EN
    lane_match_t m;
`endif

    always_comb begin
        data  = regs[addr];
        rbusy = busy[addr];
`ifdef GPR_BYPASS_EN
        m = find_lane(wen, waddr, MAX_AW'(addr));
        if (m.hit) begin
            data  = wdata[int'(m.lane)*XLEN +: XLEN];
            // A write retires the old owner; only a fresh claim keeps the register busy.
            rbusy = claim_ready && (claim_addr == addr);
        end
`endif
        if (addr == AW'(ZERO_REG)) begin
            data  = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22040759_gpr.sv
// Top level of the GPR slice: register storage, write-lane arbitration and the busy scoreboard.
module ysyx_22040759_gpr_sb
    import ysyx_22040759_gpr_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = NRD_DEF,
    parameter  int NWR  = NWR_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_addr,
    output logic                 claim_ready,
    input  logic                 flush,
    output logic [NREG-1:0]      busy_vec
);
    // Multi-port register file with write-ownership scoreboard; GPR_BYPASS_EN enables read bypass.

    logic [XLEN-1:0]           regs   [NREG];
    logic [XLEN-1:0]           wr_val [NREG];
    logic [NREG-1:0]           wr_hit;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_n;
    logic [MAX_NWR-1:0]        en_ext;
    logic [MAX_NWR*MAX_AW-1:0] addr_ext;

    // Writes to x0 are dropped here so neither storage nor bypass ever sees them.
    always_comb begin
        en_ext   = '0;
        addr_ext = '0;
        for (int i = 0; i < NWR; i++) begin
            en_ext[i] = wr_en[i] && (wr_addr[i*AW +: AW] != AW'(ZERO_REG));
            addr_ext[i*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[i*AW +: AW]);
        end
    end

    always_comb begin
        lane_match_t m;
        for (int r = 0; r < NREG; r++) begin
            m         = find_lane(en_ext, addr_ext, MAX_AW'(r));
            wr_hit[r] = m.hit;
            wr_val[r] = m.hit ? wr_data[int'(m.lane)*XLEN +: XLEN] : regs[r];
        end
    end

    assign claim_ready = claim_valid
                       && ((claim_addr == AW'(ZERO_REG)) || !busy[claim_addr])
                       && !flush;

    // Priority from lowest to highest: writes clear, claims set, flush clears everything.
    always_comb begin
        busy_n = busy & ~wr_hit;
        if (claim_ready && (claim_addr != AW'(ZERO_REG)))
            busy_n[claim_addr] = 1'b1;
        if (flush)
            busy_n = '0;
        busy_n[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= wr_val[r];
            busy <= busy_n;
        end
    end

    assign busy_vec = busy;

    for (genvar p = 0; p < NRD; p++) begin : g_rdport
        ysyx_22040759_gpr_rdport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .NWR  (NWR),
            .AW   (AW)
        ) u_rdport (
            .addr        (rd_addr[p*AW +: AW]),
            .regs        (regs),
            .busy        (busy),
`ifdef GPR_BYPASS_EN
            .wen         (en_ext),
            .waddr       (addr_ext),
            .wdata       (wr_data),
            .claim_ready (claim_ready),
            .claim_addr  (claim_addr),
`endif
            .data        (rd_data[p*XLEN +: XLEN]),
            .rbusy       (rd_busy[p])
        );
    end

endmodule
